// File: rtl/mem_stage_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: funct3 codes,
// FSM state constants, byte-lane masks and the alignment rule.
package mem_stage_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] carries the access size for both loads and stores
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [3:0] LANES_ALL     = 4'b1111;
    localparam logic [3:0] LANES_HALF_LO = 4'b0011;
    localparam logic [3:0] LANES_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_BYTE0    = 4'b0001;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_H) && offset[0]) || ((size == SIZE_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_access_unit_load_data_extractor.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it
// according to the load's funct3.
module load_data_extractor
    import mem_stage_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign shifted = word >> {offset, 3'b000};
    assign byteSel = shifted[7:0];
    assign halfSel = shifted[15:0];

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{byteSel[7]}}, byteSel};
            F3_H:    data = {{16{halfSel[15]}}, halfSel};
            F3_BU:   data = {24'b0, byteSel};
            F3_HU:   data = {16'b0, halfSel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory access unit: converts load/store control into a
// valid/ready bus transaction, stalls the pipeline meanwhile, returns load data.
module mem_stage_access_unit
    import mem_stage_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memMemRead,
    input  logic        memMemWrite,
    input  logic [2:0]  memFunct3,
    input  logic [31:0] memAddress,
    input  logic [31:0] memStoreData,
    output logic [31:0] memMemoryData,
    output logic        stall,
    output logic        misaligned,
    output logic        busError,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWData,
    output logic [3:0]  dmemByteEn,
    input  logic        dmemReady,
    input  logic        dmemRValid,
    input  logic [31:0] dmemRData
);

    state_t           state;
    state_t           nextState;
    logic [CNT_W-1:0] timeoutCnt;
    logic [31:0]      capData;
    logic [2:0]       capFunct3;
    logic [1:0]       capOffset;
    logic             capWe;
    logic             timedOut;

    logic        access;
    logic        startAccess;
    logic        inFlight;
    logic        timeoutHit;
    logic        timeoutAbort;
    logic [31:0] extracted;

    assign access      = memMemRead | memMemWrite;
    assign misaligned  = (state == ST_IDLE) & access & isMisaligned(memFunct3[1:0], memAddress[1:0]);
    assign startAccess = (state == ST_IDLE) & access & ~misaligned;
    assign inFlight    = (state == ST_REQ) | (state == ST_WAIT);
    assign timeoutHit  = (timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign stall    = startAccess | inFlight;
    assign busError = timedOut;
    assign dmemReq  = (state == ST_REQ);
    assign dmemWe   = capWe;
    // EX/MEM is frozen while stalled, so the live address is stable for the whole request
    assign dmemAddr = {memAddress[31:2], 2'b00};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dmemWData  = memStoreData;
        dmemByteEn = LANES_ALL;
        case (capFunct3[1:0])
            SIZE_B:  dmemWData = {4{memStoreData[7:0]}};
            SIZE_H:  dmemWData = {2{memStoreData[15:0]}};
            default: dmemWData = memStoreData;
        endcase
        if (capWe) begin
            case (capFunct3[1:0])
                SIZE_B:  dmemByteEn = LANE_BYTE0 << capOffset;
                SIZE_H:  dmemByteEn = capOffset[1] ? LANES_HALF_HI : LANES_HALF_LO;
                default: dmemByteEn = LANES_ALL;
            endcase
        end
    end

    always_comb begin
        nextState    = state;
        timeoutAbort = 1'b0;
        case (state)
            ST_IDLE: if (startAccess) nextState = ST_REQ;
            ST_REQ: begin
                // the terminating event wins over a timeout landing in the same cycle
                if (dmemReady) begin
                    nextState = capWe ? ST_DONE : ST_WAIT;
                end else if (timeoutHit) begin
                    nextState    = ST_DONE;
                    timeoutAbort = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmemRValid) begin
                    nextState = ST_DONE;
                end else if (timeoutHit) begin
                    nextState    = ST_DONE;
                    timeoutAbort = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            timeoutCnt <= '0;
            capData    <= '0;
            capFunct3  <= '0;
            capOffset  <= '0;
            capWe      <= 1'b0;
            timedOut   <= 1'b0;
        end else begin
            state    <= nextState;
            timedOut <= timeoutAbort;
            if (inFlight && ((nextState == ST_REQ) || (nextState == ST_WAIT)))
                timeoutCnt <= timeoutCnt + 1'b1;
            else
                timeoutCnt <= '0;
            if (startAccess) begin
                capFunct3 <= memFunct3;
                capOffset <= memAddress[1:0];
                capWe     <= memMemWrite & ~memMemRead;
            end
            if (timeoutAbort)
                capData <= '0;
            else if ((state == ST_WAIT) && dmemRValid)
                capData <= dmemRData;
        end
    end

    load_data_extractor u_extractor (
        .word   (capData),
        .offset (capOffset),
        .funct3 (capFunct3),
        .data   (extracted)
    );

    assign memMemoryData = misaligned ? 32'b0 : extracted;

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Scoreboard bench for mem_stage_access_unit: directed cases plus random traffic
// against a randomly delayed slave; a monitor pops expectations on each completion.
module tb_mem_stage_access_unit;

    localparam int TIMEOUT  = 12;
    localparam int MAX_WAIT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        memMemRead, memMemWrite;
    logic [2:0]  memFunct3;
    logic [31:0] memAddress, memStoreData;
    logic [31:0] memMemoryData;
    logic        stall, misaligned, busError;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWData;
    logic [3:0]  dmemByteEn;
    logic        dmemReady, dmemRValid;
    logic [31:0] dmemRData;

    mem_stage_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .memMemRead(memMemRead), .memMemWrite(memMemWrite), .memFunct3(memFunct3),
        .memAddress(memAddress), .memStoreData(memStoreData), .memMemoryData(memMemoryData),
        .stall(stall), .misaligned(misaligned), .busError(busError),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWData(dmemWData),
        .dmemByteEn(dmemByteEn), .dmemReady(dmemReady), .dmemRValid(dmemRValid),
        .dmemRData(dmemRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        bit          we;
        bit          berr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    bit          monOn = 1'b1;
    int          slvReadyDelay = 0;
    int          slvRvalidDelay = 0;
    logic [31:0] slvRData = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] loadValue(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * off);
        case (f3)
            3'b000:  return 32'($signed(sh[7:0]));
            3'b001:  return 32'($signed(sh[15:0]));
            3'b100:  return {24'b0, sh[7:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Slave: ready after slvReadyDelay request cycles, rvalid slvRvalidDelay cycles after the first WAIT cycle
    initial begin
        bit rvArmed = 1'b0;
        int reqCnt  = 0;
        int waitCnt = 0;
        dmemReady  = 1'b0;
        dmemRValid = 1'b0;
        dmemRData  = '0;
        forever begin
            @(negedge clk);
            dmemRValid = 1'b0;
            dmemRData  = $urandom;
            if (rvArmed) begin
                if (waitCnt == slvRvalidDelay) begin
                    dmemRValid = 1'b1;
                    dmemRData  = slvRData;
                    rvArmed    = 1'b0;
                end
                waitCnt++;
            end
            if (dmemReq === 1'b1) begin
                rvArmed   = 1'b0;
                dmemReady = (reqCnt >= slvReadyDelay);
                reqCnt++;
                if (dmemReady) begin
                    reqCnt = 0;
                    if (!dmemWe) begin
                        rvArmed = 1'b1;
                        waitCnt = 0;
                    end
                end
            end else begin
                dmemReady = 1'b0;
                reqCnt    = 0;
            end
        end
    end

    // Monitor: checks bus fields during requests and pops one expectation per completed instruction
    initial begin
        bit   prevStall = 1'b0;
        int   stallCnt  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!monOn || rst) begin
                prevStall = (stall === 1'b1);
                stallCnt  = 0;
            end else begin
                if (stall) begin
                    stallCnt++;
                    if (dmemReq) begin
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected request: addr 0x%08h with nothing issued", dmemAddr);
                        end else begin
                            e = sb[0];
                            check("req addr", dmemAddr, e.addr);
                            check("req we", 32'(dmemWe), 32'(e.we));
                            check("req byteEn", 32'(dmemByteEn), 32'(e.be));
                            if (e.we) check("req wdata", dmemWData, e.wdata);
                        end
                    end
                end else if (prevStall || misaligned) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected completion: nothing issued");
                    end else begin
                        e = sb.pop_front();
                        check("misaligned", 32'(misaligned), 32'(e.mis));
                        check("busError", 32'(busError), 32'(e.berr));
                        check("req at completion", 32'(dmemReq), 32'(0));
                        check("stall cycles", 32'(stallCnt), 32'(e.stalls));
                        if (e.mis || !e.we) check("load data", memMemoryData, e.data);
                    end
                    stallCnt = 0;
                end else begin
                    check("idle busError", 32'(busError), 32'(0));
                    check("idle req", 32'(dmemReq), 32'(0));
                end
                prevStall = stall;
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input int rdyDly, input int rvDly);
        exp_t e;
        int   n;
        int   reqWait;
        int   budget;
        n       = 1 << f3[1:0];
        e.we    = wr && !rd;
        e.mis   = (int'(addr[1:0]) % n) != 0;
        e.addr  = addr & ~32'h3;
        e.be    = e.we ? 4'(((1 << n) - 1) << addr[1:0]) : 4'hF;
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sdata[8*(i % n) +: 8];
        reqWait  = rdyDly + 1 + (e.we ? 0 : rvDly + 1);
        e.berr   = !e.mis && (reqWait > TIMEOUT);
        e.stalls = e.mis ? 0 : 1 + (e.berr ? TIMEOUT : reqWait);
        e.data   = (e.mis || e.berr) ? 32'b0 : loadValue(f3, addr[1:0], rdata);
        sb.push_back(e);

        slvReadyDelay  = rdyDly;
        slvRvalidDelay = rvDly;
        slvRData       = rdata;
        memMemRead     = rd;
        memMemWrite    = wr;
        memFunct3      = f3;
        memAddress     = addr;
        memStoreData   = sdata;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (stall === 1'b1 && budget < MAX_WAIT);
        if (budget >= MAX_WAIT) begin
            checks++; errors++;
            $display("FAIL completion timeout: still stalled after %0d cycles", budget);
        end
        @(posedge clk);
        #1;
        memMemRead  = 1'b0;
        memMemWrite = 1'b0;
    endtask

    initial begin
        int          r;
        bit          rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  loadCodes [5];
        loadCodes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst = 1'b1;
        memMemRead = 1'b0; memMemWrite = 1'b0; memFunct3 = '0;
        memAddress = '0; memStoreData = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset stall", 32'(stall), 32'(0));
        check("reset req", 32'(dmemReq), 32'(0));
        check("reset busError", 32'(busError), 32'(0));
        check("reset data", memMemoryData, 32'h0);
        @(posedge clk); #1;

        // directed cases
        issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);              // SW
        issue(1, 0, 3'b000, 32'h203, 0, 32'h80FF_7F01, 0, 0);             // LB
        issue(1, 0, 3'b100, 32'h203, 0, 32'h80FF_7F01, 0, 0);             // LBU
        issue(0, 1, 3'b001, 32'h102, 32'hAAAA_1234, 0, 0, 0);             // SH
        issue(1, 0, 3'b001, 32'h102, 0, 32'h8001_0000, 0, 0);             // LH
        issue(1, 0, 3'b010, 32'h101, 0, 32'h1234_5678, 0, 0);             // misaligned LW
        issue(0, 1, 3'b000, 32'h3F1, 32'h0000_00A5, 0, 1, 0);             // SB lane 1
        issue(1, 0, 3'b010, 32'h400, 0, 32'hCAFE_F00D, 5, 3);             // slow slave
        issue(0, 1, 3'b010, 32'h500, 32'h1111_2222, 0, TIMEOUT - 1, 0);   // ready on last allowed cycle
        issue(0, 1, 3'b010, 32'h504, 32'h3333_4444, 0, TIMEOUT, 0);       // one cycle too late
        issue(0, 1, 3'b010, 32'h508, 32'h5555_6666, 0, 100, 0);           // never ready
        issue(1, 0, 3'b101, 32'h60E, 0, 32'hBEEF_0000, 0, 50);            // rvalid never in time
        issue(1, 1, 3'b010, 32'h700, 32'h7777_7777, 32'h0BAD_F00D, 0, 0); // read wins over write

        // reset while waiting for read data; the late rvalid must be ignored
        monOn = 1'b0;
        slvReadyDelay = 0; slvRvalidDelay = 6; slvRData = 32'hFFFF_FFFF;
        memMemRead = 1'b1; memFunct3 = 3'b010; memAddress = 32'h800;
        repeat (3) @(negedge clk);
        check("wait stall", 32'(stall), 32'(1));
        check("wait no req", 32'(dmemReq), 32'(0));
        rst = 1'b1;
        memMemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("post-reset stall", 32'(stall), 32'(0));
            check("post-reset req", 32'(dmemReq), 32'(0));
            check("post-reset data", memMemoryData, 32'h0);
        end
        monOn = 1'b1;
        @(posedge clk); #1;
        issue(1, 0, 3'b010, 32'h804, 0, 32'h1357_9BDF, 0, 0);

        // random traffic
        for (int k = 0; k < 150; k++) begin
            r  = $urandom_range(0, 9);
            rd = (r <= 4) || (r == 9);
            wr = (r >= 5);
            f3 = wr && !rd ? 3'($urandom_range(0, 2)) : loadCodes[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            issue(rd, wr, f3, addr, $urandom, $urandom,
                  ($urandom_range(0, 9) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
